// File: rtl/freq_set_pkg.sv
// Shared definitions for the frequency-setting keypad controller.
//   - state_e  : controller FSM states
//   - key_e    : identifiers of the three keys (up, down, step)
//   - STEP_*   : step_sel encodings
//   - STEP*_VAL: increment sizes selected by step_sel, at 10 bits so sums never wrap
//   - FMAX     : largest frequency code
package freq_set_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_HELD     = 3'd2,
        ST_REPEAT   = 3'd3,
        ST_RELEASE  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        KEY_UP   = 2'd0,
        KEY_DN   = 2'd1,
        KEY_STEP = 2'd2
    } key_e;

    localparam logic [1:0] STEP_1   = 2'd0;
    localparam logic [1:0] STEP_10  = 2'd1;
    localparam logic [1:0] STEP_100 = 2'd2;

    localparam logic [9:0] STEP1_VAL   = 10'd1;
    localparam logic [9:0] STEP10_VAL  = 10'd10;
    localparam logic [9:0] STEP100_VAL = 10'd100;

    localparam int FMAX = 511;

    // Increment size for a step_sel code; the unused code 3 falls back to 1.
    function automatic logic [9:0] step_val(input logic [1:0] sel);
        case (sel)
            STEP_10:  step_val = STEP10_VAL;
            STEP_100: step_val = STEP100_VAL;
            default:  step_val = STEP1_VAL;
        endcase
    endfunction

    // Step selection cycles 1 -> 10 -> 100 -> 1.
    function automatic logic [1:0] step_next(input logic [1:0] sel);
        case (sel)
            STEP_1:  step_next = STEP_10;
            STEP_10: step_next = STEP_100;
            default: step_next = STEP_1;
        endcase
    endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for one asynchronous active-low key.
// Ports:
//   clk    - system clock
//   rst_n  - synchronous active-low reset; both flops reset to 1 (key released)
//   key_n  - raw asynchronous key input, active low
//   key_s  - synchronized key, active low, two cycles behind key_n
module key_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic key_s
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta  <= 1'b1;
            key_s <= 1'b1;
        end else begin
            meta  <= key_n;
            key_s <= meta;
        end
    end

endmodule

// File: rtl/freq_set_ctrl.sv
// Keypad controller that sets a 9-bit frequency code with up/down/step keys.
// Each key is synchronized, debounced, and (for up/down) auto-repeats when held.
// Ports:
//   clk        - system clock, all logic on rising edge
//   rst_n      - synchronous active-low reset
//   key_up_n   - increment key, asynchronous, active low
//   key_dn_n   - decrement key, asynchronous, active low
//   key_step_n - step-select key, asynchronous, active low
//   freq       - registered frequency code 0..511
//   step_sel   - current step: 0 = 1, 1 = 10, 2 = 100
//   freq_vld   - one-cycle strobe, high exactly in the cycle freq shows a new,
//                different value; it has no ready, so consumers must capture
//                freq whenever the strobe is high
// The FSM state is held in the internal signal 'state' (type state_e).
module freq_set_ctrl
    import freq_set_pkg::*;
#(
    parameter int DEB_CYCLES    = 500000,
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000,
    parameter int FRESET        = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_up_n,
    input  logic       key_dn_n,
    input  logic       key_step_n,
    output logic [8:0] freq,
    output logic [1:0] step_sel,
    output logic       freq_vld
);

    // One counter serves all timed states, so size it for the longest interval.
    localparam int CMAX_A = (DEB_CYCLES > HOLD_CYCLES) ? DEB_CYCLES : HOLD_CYCLES;
    localparam int CMAX   = (CMAX_A > REPEAT_CYCLES) ? CMAX_A : REPEAT_CYCLES;
    localparam int CW     = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
    localparam logic [8:0]    FRESET9   = 9'(FRESET);
    localparam logic [9:0]    FMAX10    = 10'(FMAX);

    logic up_s, dn_s, step_s;

    key_sync u_sync_up   (.clk(clk), .rst_n(rst_n), .key_n(key_up_n),   .key_s(up_s));
    key_sync u_sync_dn   (.clk(clk), .rst_n(rst_n), .key_n(key_dn_n),   .key_s(dn_s));
    key_sync u_sync_step (.clk(clk), .rst_n(rst_n), .key_n(key_step_n), .key_s(step_s));

    state_e        state;
    key_e          key_id;
    logic [CW-1:0] cnt;

    logic [2:0] keys_low;
    logic       one_low;
    logic       any_low;
    key_e       low_id;
    logic       held_low;
    logic       fire;
    logic [9:0] sum;
    logic signed [10:0] diff;
    logic [8:0] up_val;
    logic [8:0] dn_val;
    logic [8:0] act_freq;

    assign keys_low = {~step_s, ~dn_s, ~up_s};
    assign any_low  = |keys_low;

    // Identify a single pressed key; simultaneous presses are not a valid start.
    always_comb begin
        one_low = 1'b1;
        low_id  = KEY_UP;
        case (keys_low)
            3'b001:  low_id = KEY_UP;
            3'b010:  low_id = KEY_DN;
            3'b100:  low_id = KEY_STEP;
            default: one_low = 1'b0;
        endcase
    end

    // Only the latched key matters once a press is in progress.
    always_comb begin
        case (key_id)
            KEY_UP:   held_low = keys_low[0];
            KEY_DN:   held_low = keys_low[1];
            KEY_STEP: held_low = keys_low[2];
            default:  held_low = 1'b0;
        endcase
    end

    // Saturating arithmetic: the sum is one bit wider and the difference is
    // signed, so neither can wrap before the clamp.
    always_comb begin
        sum      = {1'b0, freq} + step_val(step_sel);
        diff     = $signed({2'b00, freq}) - $signed({1'b0, step_val(step_sel)});
        up_val   = (sum > FMAX10) ? FMAX10[8:0] : sum[8:0];
        dn_val   = (diff < 0) ? 9'd0 : diff[8:0];
        act_freq = (key_id == KEY_UP) ? up_val : dn_val;
    end

    // An action happens on the cycle the counter shows the last value of a
    // timed interval with the key still down; the step key never repeats.
    always_comb begin
        fire = 1'b0;
        if (held_low) begin
            case (state)
                ST_DEBOUNCE: fire = (cnt == DEB_LAST);
                ST_HELD:     fire = (key_id != KEY_STEP) && (cnt == HOLD_LAST);
                ST_REPEAT:   fire = (cnt == REP_LAST);
                default:     fire = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            key_id   <= KEY_UP;
            cnt      <= '0;
            freq     <= FRESET9;
            step_sel <= STEP_1;
            freq_vld <= 1'b0;
        end else begin
            freq_vld <= 1'b0;
            if (fire) begin
                if (key_id == KEY_STEP) begin
                    step_sel <= step_next(step_sel);
                end else begin
                    freq     <= act_freq;
                    freq_vld <= (act_freq != freq);
                end
            end

            case (state)
                ST_IDLE: begin
                    if (one_low) begin
                        key_id <= low_id;
                        cnt    <= '0;
                        state  <= ST_DEBOUNCE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!held_low) begin
                        state <= ST_IDLE;
                    end else if (cnt == DEB_LAST) begin
                        cnt   <= '0;
                        state <= ST_HELD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!held_low) begin
                        cnt   <= '0;
                        state <= ST_RELEASE;
                    end else if (key_id == KEY_STEP) begin
                        cnt <= cnt;
                    end else if (cnt == HOLD_LAST) begin
                        cnt   <= '0;
                        state <= ST_REPEAT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (!held_low) begin
                        cnt   <= '0;
                        state <= ST_RELEASE;
                    end else if (cnt == REP_LAST) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    // Wait for all keys quiet so release bounce is not a new press.
                    if (any_low) begin
                        cnt <= '0;
                    end else if (cnt == DEB_LAST) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_set_ctrl.sv
// Self-checking bench for freq_set_ctrl with short timing parameters.
// A behavioural model describes each press by its age (cycles since the press
// was first seen) and derives the action times from the timing parameters.
module tb_freq_set_ctrl;

    localparam int DEB  = 4;
    localparam int HOLD = 20;
    localparam int REP  = 5;
    localparam int FRST = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_up_n = 1'b1;
    logic       key_dn_n = 1'b1;
    logic       key_step_n = 1'b1;
    logic [8:0] freq;
    logic [1:0] step_sel;
    logic       freq_vld;

    int checks = 0;
    int errors = 0;
    int vld_cnt = 0;
    bit started = 1'b0;

    freq_set_ctrl #(
        .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .FRESET(FRST)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_up_n(key_up_n), .key_dn_n(key_dn_n),
        .key_step_n(key_step_n), .freq(freq), .step_sel(step_sel), .freq_vld(freq_vld)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    typedef enum {PH_IDLE, PH_PRESS, PH_QUIET} phase_e;
    phase_e m_ph = PH_IDLE;
    int   m_age = 0, m_quiet = 0, m_key = 0;
    logic [2:0] m_d1 = 3'b111, m_d2 = 3'b111;   // raw keys delayed 1 and 2 cycles
    int   m_freq = FRST, m_step = 0;
    bit   m_vld = 1'b0;

    function automatic bit due(input int age, input int key);
        if (age == DEB) return 1'b1;
        if (key == 2) return 1'b0;
        return (age >= DEB + HOLD) && ((age - DEB - HOLD) % REP == 0);
    endfunction

    function automatic void act(input int key);
        int sv, nf;
        sv = (m_step == 0) ? 1 : (m_step == 1) ? 10 : 100;
        if (key == 2) begin
            m_step = (m_step + 1) % 3;
        end else begin
            nf = (key == 0) ? m_freq + sv : m_freq - sv;
            if (nf > 511) nf = 511;
            if (nf < 0) nf = 0;
            m_vld  = (nf != m_freq);
            m_freq = nf;
        end
    endfunction

    always @(posedge clk) begin
        int lows;
        if (!rst_n) begin
            m_ph = PH_IDLE; m_age = 0; m_quiet = 0;
            m_d1 = 3'b111; m_d2 = 3'b111;
            m_freq = FRST; m_step = 0; m_vld = 1'b0;
        end else begin
            m_vld = 1'b0;
            lows = 0;
            for (int i = 0; i < 3; i++) if (!m_d2[i]) lows++;
            case (m_ph)
                PH_IDLE: if (lows == 1) begin
                    for (int i = 0; i < 3; i++) if (!m_d2[i]) m_key = i;
                    m_age = 0;
                    m_ph  = PH_PRESS;
                end
                PH_PRESS: begin
                    m_age++;
                    if (m_d2[m_key]) begin
                        m_quiet = 0;
                        m_ph = (m_age <= DEB) ? PH_IDLE : PH_QUIET;
                    end else if (due(m_age, m_key)) begin
                        act(m_key);
                    end
                end
                default: begin
                    if (lows > 0) m_quiet = 0;
                    else begin
                        m_quiet++;
                        if (m_quiet == DEB) m_ph = PH_IDLE;
                    end
                end
            endcase
            m_d2 = m_d1;
            m_d1 = {key_step_n, key_dn_n, key_up_n};
        end
    end

    // Compare process: outputs checked every cycle, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            chk("freq", int'(freq), m_freq);
            chk("step_sel", int'(step_sel), m_step);
            chk("freq_vld", int'(freq_vld), int'(m_vld));
        end
    end

    always @(posedge clk) if (freq_vld === 1'b1) vld_cnt++;

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_keys(input logic u, input logic d, input logic s);
        key_up_n = u; key_dn_n = d; key_step_n = s;
    endtask

    task automatic do_reset();
        set_keys(1, 1, 1);
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
    endtask

    // Hold one key (0 up, 1 down, 2 step) low for n cycles, release, let it settle.
    task automatic tap(input int which, input int n);
        set_keys(which != 0, which != 1, which != 2);
        cyc(n);
        set_keys(1, 1, 1);
        cyc(DEB + 8);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int v0;
        rst_n = 1'b0;
        cyc(3);
        started = 1'b1;
        rst_n = 1'b1;
        cyc(1);

        // reset state
        chk("reset_freq", int'(freq), 100);
        chk("reset_step", int'(step_sel), 0);
        chk("reset_vld", int'(freq_vld), 0);

        // short press and glitch
        v0 = vld_cnt;
        tap(0, 8);
        chk("short_press_freq", int'(freq), 101);
        chk("short_press_pulses", vld_cnt - v0, 1);
        v0 = vld_cnt;
        tap(0, 3);
        chk("glitch_freq", int'(freq), 101);
        chk("glitch_pulses", vld_cnt - v0, 0);

        // step twice then down, then down at zero
        do_reset();
        tap(2, 8);
        tap(2, 8);
        chk("step_twice", int'(step_sel), 2);
        v0 = vld_cnt;
        tap(1, 8);
        chk("down_freq", int'(freq), 0);
        chk("down_pulses", vld_cnt - v0, 1);
        v0 = vld_cnt;
        tap(1, 8);
        chk("down_sat_freq", int'(freq), 0);
        chk("down_sat_pulses", vld_cnt - v0, 0);

        // climb to 505, then saturate with step 10
        do_reset();
        tap(2, 8); tap(2, 8);
        for (int i = 0; i < 4; i++) tap(0, 8);
        tap(2, 8);
        for (int i = 0; i < 5; i++) tap(0, 8);
        tap(2, 8);
        chk("pre_sat_freq", int'(freq), 505);
        chk("pre_sat_step", int'(step_sel), 1);
        v0 = vld_cnt;
        tap(0, 8);
        chk("up_sat_freq", int'(freq), 511);
        chk("up_sat_pulses", vld_cnt - v0, 1);
        v0 = vld_cnt;
        tap(0, 8);
        chk("up_sat2_freq", int'(freq), 511);
        chk("up_sat2_pulses", vld_cnt - v0, 0);

        // auto-repeat: actions at press ages 4, 24, 29, 34, 39, 44
        do_reset();
        v0 = vld_cnt;
        tap(0, 46);
        chk("repeat_freq", int'(freq), 106);
        chk("repeat_pulses", vld_cnt - v0, 6);
        cyc(20);
        chk("repeat_stopped", int'(freq), 106);

        // simultaneous keys do nothing
        do_reset();
        set_keys(0, 0, 1);
        cyc(12);
        set_keys(1, 1, 1);
        cyc(DEB + 8);
        chk("simul_freq", int'(freq), 100);
        chk("simul_step", int'(step_sel), 0);

        // reset in the middle of auto-repeat with the key still held
        do_reset();
        set_keys(0, 1, 1);
        cyc(34);
        chk("mid_repeat_freq", int'(freq), 103);
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        chk("after_reset_freq", int'(freq), 100);
        cyc(10);
        set_keys(1, 1, 1);
        cyc(DEB + 8);
        chk("redebounce_freq", int'(freq), 101);

        // randomized key activity, checked cycle by cycle against the model
        for (int seg = 0; seg < 160; seg++) begin
            int pick;
            pick = $urandom_range(0, 9);
            if (pick < 6) set_keys(pick % 3 != 0, pick % 3 != 1, pick % 3 != 2);
            else set_keys(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            cyc($urandom_range(1, 45));
            set_keys(1, 1, 1);
            cyc($urandom_range(0, 12));
            if ($urandom_range(0, 39) == 0) do_reset();
        end
        set_keys(1, 1, 1);
        cyc(DEB + 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
